iter_div_unit: RTL



---
 rtl/iter_div_unit.sv | 100 ++++++++++
 1 files changed

// File: rtl/iter_div_unit.sv
// iter_div_unit: multi-cycle radix-2 restoring divider producing quotient and remainder
module iter_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             start,
  output logic             is_running,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, orig_q, orig_d;
  logic [WIDTH-1:0] qout_q, qout_d, rout_q, rout_d;
  logic             sa_q, sa_d, sb_q, sb_d, run_q, run_d, done_q, done_d;
  logic [WIDTH:0]   sh;
  logic             ge;
  assign sh = {rem_q, quo_q[WIDTH-1]};
  assign ge = sh >= {1'b0, dvs_q};
  // next-state: latch magnitudes on start, one restoring step per CALC edge, sign fix in FIX
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    orig_d  = orig_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    run_d   = run_q;
    qout_d  = qout_q;
    rout_d  = rout_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        sa_d    = op & dividend[WIDTH-1];
        sb_d    = op & divisor[WIDTH-1];
        quo_d   = sa_d ? -dividend : dividend;
        dvs_d   = sb_d ? -divisor : divisor;
        orig_d  = dividend;
        rem_d   = '0;
        cnt_d   = '0;
        run_d   = 1'b1;
        state_d = CALC;
      end
    end else if (state_q == CALC) begin
      rem_d   = ge ? sh[WIDTH-1:0] - dvs_q : sh[WIDTH-1:0];
      quo_d   = {quo_q[WIDTH-2:0], ge};
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == CW'(WIDTH - 1)) ? FIX : CALC;
    end else begin
      qout_d  = (dvs_q == '0) ? '1 : (sa_q ^ sb_q) ? -quo_q : quo_q;
      rout_d  = (dvs_q == '0) ? orig_q : sa_q ? -rem_q : rem_q;
      done_d  = 1'b1;
      run_d   = 1'b0;
      state_d = IDLE;
    end
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      orig_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      run_q   <= 1'b0;
      qout_q  <= '0;
      rout_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      orig_q  <= orig_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      run_q   <= run_d;
      qout_q  <= qout_d;
      rout_q  <= rout_d;
      done_q  <= done_d;
    end
  end
  assign is_running    = run_q;
  assign quotient_out  = qout_q;
  assign remainder_out = rout_q;
  assign done          = done_q;
endmodule
